// File: rtl/lock_seq_param.sv
// -----------------------------------------------------------------------------
// lock_seq_param
//   Serial combination lock built as a Moore FSM. Bits arrive one per valid
//   cycle, MSB of CODE first. The full combination gives UNLOCK for
//   UNLOCK_HOLD cycles. A wrong bit gives ERROR, which is held while x_valid
//   stays high. All flags are registered and decode the FSM state only.
//
//   Optional feature (macro LOCK_SEQ_LOCKOUT_EN):
//     Failed attempts are counted, saturating at MAX_TRIES. The ERROR exit
//     that follows the MAX_TRIES-th failure enters LOCKOUT for LOCKOUT_CYCLES
//     cycles. Input is ignored during LOCKOUT. When the macro is undefined
//     there is no counter, no timer and no LOCKOUT state, and locked_out and
//     fail_count are tied to 0.
//
// Ports
//   clock       in   free-running clock, rising-edge active
//   reset       in   synchronous, active-high reset
//   x_valid     in   x carries an entered bit this cycle
//   x           in   entered combination bit
//   ready       out  idle and awaiting the first bit
//   unlock      out  correct combination accepted
//   error       out  wrong bit entered
//   locked_out  out  too many failures; input ignored
//   fail_count  out  consecutive failed attempts, $clog2(MAX_TRIES+1) bits
// -----------------------------------------------------------------------------
module lock_seq_param #(
    parameter int unsigned         CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] CODE           = 5'b10101,
    parameter int unsigned         UNLOCK_HOLD    = 3,
    parameter int unsigned         MAX_TRIES      = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             x_valid,
    input  logic                             x,
    output logic                             ready,
    output logic                             unlock,
    output logic                             error,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int unsigned FC_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned HOLD_W = (UNLOCK_HOLD > 1) ? $clog2(UNLOCK_HOLD) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(UNLOCK_HOLD - 1);

`ifdef LOCK_SEQ_LOCKOUT_EN
    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LAST_LOCK = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]   FC_MAX    = FC_W'(MAX_TRIES);
`endif

    typedef enum logic [2:0] {
        ST_READY,
        ST_ENTRY,
        ST_UNLOCK,
        ST_ERROR
`ifdef LOCK_SEQ_LOCKOUT_EN
        , ST_LOCKOUT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;

    logic                ready_q;
    logic                unlock_q;
    logic                error_q;

`ifdef LOCK_SEQ_LOCKOUT_EN
    logic [FC_W-1:0]     fc_q,    fc_d;
    logic [LOCK_W-1:0]   tmr_q,   tmr_d;
    logic                lo_q;
`else
    // Lockout sizing only matters when the feature is built in.
    logic                unused_lockout_cfg;
    assign unused_lockout_cfg = ^LOCKOUT_CYCLES;
`endif

    // Combination reversed so the bit index selects the expected bit directly.
    logic [CODE_LEN-1:0] code_rev;
    for (genvar g = 0; g < CODE_LEN; g++) begin : g_rev
        assign code_rev[g] = CODE[CODE_LEN-1-g];
    end

    logic bit_ok_c;
    assign bit_ok_c = (x == code_rev[idx_q]);

    // Next-state, index, and timer logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
`ifdef LOCK_SEQ_LOCKOUT_EN
        fc_d    = fc_q;
        tmr_d   = tmr_q;
`endif
        case (state_q)
            ST_READY, ST_ENTRY: begin
                if (x_valid) begin
                    if (!bit_ok_c) begin
                        state_d = ST_ERROR;
                        idx_d   = '0;
`ifdef LOCK_SEQ_LOCKOUT_EN
                        if (fc_q != FC_MAX) begin
                            fc_d = fc_q + FC_W'(1);
                        end
`endif
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_UNLOCK;
                        idx_d   = '0;
                        hold_d  = '0;
`ifdef LOCK_SEQ_LOCKOUT_EN
                        fc_d    = '0;
`endif
                    end else begin
                        state_d = ST_ENTRY;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_UNLOCK: begin
                if (hold_q == LAST_HOLD) begin
                    state_d = ST_READY;
                    idx_d   = '0;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end

            ST_ERROR: begin
                // Held while x_valid is high; the exit target depends on the
                // failure count reached on entry.
                if (!x_valid) begin
                    idx_d   = '0;
`ifdef LOCK_SEQ_LOCKOUT_EN
                    if (fc_q == FC_MAX) begin
                        state_d = ST_LOCKOUT;
                        tmr_d   = '0;
                    end else begin
                        state_d = ST_READY;
                    end
`else
                    state_d = ST_READY;
`endif
                end
            end

`ifdef LOCK_SEQ_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (tmr_q == LAST_LOCK) begin
                    state_d = ST_READY;
                    idx_d   = '0;
                    fc_d    = '0;
                end else begin
                    tmr_d   = tmr_q + LOCK_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_READY;
                idx_d   = '0;
            end
        endcase
    end

    // State and registered Moore flags, decoded from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_READY;
            idx_q    <= '0;
            hold_q   <= '0;
            ready_q  <= 1'b1;
            unlock_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef LOCK_SEQ_LOCKOUT_EN
            fc_q     <= '0;
            tmr_q    <= '0;
            lo_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            ready_q  <= (state_d == ST_READY);
            unlock_q <= (state_d == ST_UNLOCK);
            error_q  <= (state_d == ST_ERROR);
`ifdef LOCK_SEQ_LOCKOUT_EN
            fc_q     <= fc_d;
            tmr_q    <= tmr_d;
            lo_q     <= (state_d == ST_LOCKOUT);
`endif
        end
    end

    assign ready  = ready_q;
    assign unlock = unlock_q;
    assign error  = error_q;

`ifdef LOCK_SEQ_LOCKOUT_EN
    assign locked_out = lo_q;
    assign fail_count = fc_q;
`else
    assign locked_out = 1'b0;
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_lock_seq_param.sv
// -----------------------------------------------------------------------------
// tb_lock_seq_param
//   Directed bench for lock_seq_param with default parameters. Each stimulus
//   cycle pushes the hand-derived state it should produce into a scoreboard.
//   A monitor pops one entry per clock and compares every output. The state
//   codes are: R=ready, E=entry (no flag), U=unlock, X=error, L=locked out.
// -----------------------------------------------------------------------------
module tb_lock_seq_param;

    localparam int unsigned FC_W = 2;
`ifdef LOCK_SEQ_LOCKOUT_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            x_valid;
    logic            x;
    logic            ready;
    logic            unlock;
    logic            error;
    logic            locked_out;
    logic [FC_W-1:0] fail_count;

    typedef struct {
        int              id;
        byte             st;
        logic [FC_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    exp_t       mon_e;
    logic [5:0] mon_got;
    logic [5:0] mon_exp;

    lock_seq_param dut (
        .clock      (clock),
        .reset      (reset),
        .x_valid    (x_valid),
        .x          (x),
        .ready      (ready),
        .unlock     (unlock),
        .error      (error),
        .locked_out (locked_out),
        .fail_count (fail_count)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] expect_vec(input byte st, input logic [FC_W-1:0] fc);
        expect_vec = {st == "R", st == "U", st == "X", st == "L", fc};
    endfunction

    // Monitor: one comparison per clock while expectations are pending.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_exp = expect_vec(mon_e.st, mon_e.fc);
            mon_got = {ready, unlock, error, locked_out, fail_count};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL vec%0d (state %s): got rdy,unl,err,lo,fc=%b required %b",
                         mon_e.id, mon_e.st, mon_got, mon_exp);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic v, input logic xb,
                       input byte st, input int fc);
        exp_t e;
        @(negedge clock);
        reset   = r;
        x_valid = v;
        x       = xb;
        e.id    = vec_id;
        e.st    = st;
        e.fc    = FC_W'(fc);
        vec_id++;
        sb.push_back(e);
    endtask

    // Correct 10101 entry followed by the full unlock hold and return to ready.
    task automatic unlock_seq(input int fc_pre);
        cyc(0, 1, 1, "E", fc_pre);
        cyc(0, 1, 0, "E", fc_pre);
        cyc(0, 1, 1, "E", fc_pre);
        cyc(0, 1, 0, "E", fc_pre);
        cyc(0, 1, 1, "U", 0);
        cyc(0, 0, 0, "U", 0);
        cyc(0, 0, 0, "U", 0);
        cyc(0, 0, 0, "R", 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        x       = 1'b0;

        // Reset state; reset overrides a valid bit.
        cyc(1, 0, 0, "R", 0);
        cyc(1, 1, 1, "R", 0);

        // Correct code; x_valid during unlock is ignored; 3 unlock cycles.
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "U", 0);
        cyc(0, 1, 0, "U", 0);
        cyc(0, 1, 1, "U", 0);
        cyc(0, 0, 0, "R", 0);
        cyc(0, 0, 0, "R", 0);

        // 1,0,1,1: error on the fourth bit, held while valid, exit on gap.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 1, "X", LO);
        cyc(0, 1, 1, "X", LO);
        cyc(0, 1, 0, "X", LO);
        cyc(0, 1, 1, "X", LO);
        cyc(0, 0, 0, "R", LO);

        // Gaps inside an entry are tolerated.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, "E", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "U", 0);
        cyc(0, 0, 0, "U", 0);
        cyc(0, 0, 0, "U", 0);
        cyc(0, 0, 0, "R", 0);

        // Wrong first bit straight from ready; a new entry may then start.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 0, "X", LO);
        cyc(0, 0, 0, "R", LO);
        cyc(0, 1, 1, "E", LO);

        // Wrong last bit.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 0, "X", LO);
        cyc(0, 0, 0, "R", LO);

        // Reset during the third bit, then during unlock, then a clean unlock.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(1, 1, 1, "R", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "E", 0);
        cyc(0, 1, 0, "E", 0);
        cyc(0, 1, 1, "U", 0);
        cyc(0, 0, 0, "U", 0);
        cyc(1, 0, 0, "R", 0);
        unlock_seq(0);

        // Reset aborts error.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 0, "X", LO);
        cyc(1, 1, 1, "R", 0);

`ifdef LOCK_SEQ_LOCKOUT_EN
        // Three failures lead to an 8-cycle lockout that ignores input.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 0, "X", 1);
        cyc(0, 0, 0, "R", 1);
        cyc(0, 1, 0, "X", 2);
        cyc(0, 0, 0, "R", 2);
        cyc(0, 1, 0, "X", 3);
        cyc(0, 1, 1, "X", 3);
        cyc(0, 0, 0, "L", 3);
        cyc(0, 1, 1, "L", 3);
        cyc(0, 1, 0, "L", 3);
        cyc(0, 1, 1, "L", 3);
        cyc(0, 1, 0, "L", 3);
        cyc(0, 1, 1, "L", 3);
        cyc(0, 0, 0, "L", 3);
        cyc(0, 0, 0, "L", 3);
        cyc(0, 0, 0, "R", 0);
        unlock_seq(0);

        // Two failures, then a correct entry clears the count.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 0, "X", 1);
        cyc(0, 0, 0, "R", 1);
        cyc(0, 1, 0, "X", 2);
        cyc(0, 0, 0, "R", 2);
        unlock_seq(2);

        // Reset aborts lockout.
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 0, "X", 1);
        cyc(0, 0, 0, "R", 1);
        cyc(0, 1, 0, "X", 2);
        cyc(0, 0, 0, "R", 2);
        cyc(0, 1, 0, "X", 3);
        cyc(0, 0, 0, "L", 3);
        cyc(0, 0, 0, "L", 3);
        cyc(1, 0, 0, "R", 0);
        cyc(0, 1, 1, "E", 0);
`endif

        // Let the monitor drain the scoreboard within a bounded time.
        cyc(0, 0, 0, "R", 0);
        repeat (3) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
